// File: rtl/dn_cntr_4_if.sv
// dn_cntr_4_if: control/status bundle between a controller and the
// dn_cntr_4 down-counter. The controller drives load/start/en and watches
// the count and its status flags.
interface dn_cntr_4_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic [WIDTH-1:0] y;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, en,
        input  y, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, en,
        output y, tc, busy, done
    );
endinterface

// File: rtl/dn_cntr_4.sv
// dn_cntr_4: loadable down-counter / one-shot timer.
// A programmed value is captured by load, start counts it down to zero under
// en, and tc pulses for one cycle when the count first reads zero.
// Input priority: rst > load > start > en. All outputs are registered.
// Optional macro DN_CNTR_AUTO_RELOAD_EN: terminal count stays in RUN and the
// next enabled cycle reloads the count, giving a periodic tc.
module dn_cntr_4 #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    dn_cntr_4_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] r_y;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    logic             w_reload_zero;
    assign w_reload_zero = (r_reload == '0);

    // Control FSM with count register and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_reload <= '0;
            r_y      <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // tc is a single-cycle pulse; only a terminal event re-raises it.
            r_tc <= 1'b0;
            if (bus.load) begin
                // Load aborts anything in progress and wins over a
                // coincident terminal count, so no tc here.
                r_reload <= bus.load_val;
                r_y      <= bus.load_val;
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            r_y <= r_reload;
                            if (w_reload_zero) begin
                                // Zero-length count: terminal immediately.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_tc    <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                                r_done  <= 1'b0;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        // start is ignored while running; en=0 holds all.
                        if (bus.en) begin
                            if (r_y > ONE) begin
                                r_y <= r_y - ONE;
                            end else if (r_y == ONE) begin
                                r_y  <= '0;
                                r_tc <= 1'b1;
`ifdef DN_CNTR_AUTO_RELOAD_EN
                                // Stay in RUN; next enabled cycle reloads.
                                r_state <= S_RUN;
`else
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
`endif
                            end else begin
`ifdef DN_CNTR_AUTO_RELOAD_EN
                                // y==0 in RUN only follows a terminal count.
                                r_y <= r_reload;
`else
                                // Unreachable: RUN is never entered at zero.
                                r_y <= '0;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.y    = r_y;
    assign bus.tc   = r_tc;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_dn_cntr_4.sv
// tb_dn_cntr_4: directed scenarios with constant expectations plus a
// randomized run checked against a behavioural model of the counter.
module tb_dn_cntr_4;

    localparam int W = 4;

    logic clk;
    logic rst;

    dn_cntr_4_if #(.WIDTH(W)) bus ();

    dn_cntr_4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Behavioural model: remaining count, running/finished flags, tc pulse.
    int m_y    = 0;
    int m_rel  = 0;
    bit m_run  = 0;
    bit m_done = 0;
    bit m_tc   = 0;

    task automatic model_step();
        m_tc = 0;
        if (rst) begin
            m_y = 0; m_rel = 0; m_run = 0; m_done = 0;
        end else if (bus.load) begin
            m_rel = int'(bus.load_val); m_y = m_rel; m_run = 0; m_done = 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_y = m_rel;
                if (m_rel == 0) begin
                    m_done = 1; m_tc = 1;
                end else begin
                    m_run = 1; m_done = 0;
                end
            end
        end else if (bus.en) begin
            if (m_y == 0) begin
                m_y = m_rel;
            end else begin
                m_y = m_y - 1;
                if (m_y == 0) begin
                    m_tc = 1;
`ifndef DN_CNTR_AUTO_RELOAD_EN
                    m_run = 0; m_done = 1;
`endif
                end
            end
        end
    endtask

    task automatic drive(input bit ld, input int lv, input bit st, input bit e);
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.start    = st;
        bus.en       = e;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(0, 0, 0, 0); tick(); tick();
        rst = 1'b0;
        drive(1, 7, 0, 0); tick();
        drive(0, 0, 1, 1); tick();
        drive(0, 0, 0, 0); tick();
        // y=7 and running; reset for two cycles with en held high.
        rst = 1'b1; drive(0, 0, 0, 1); tick(); tick();
        rst = 1'b0; tick();
        n_run++;
        if (bus.y !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: y=%0d tc=%b busy=%b done=%b, expected y=0 tc=0 busy=0 done=0",
                     bus.y, bus.tc, bus.busy, bus.done);
        end
        // start with reload_reg cleared -> zero-length count proves IDLE and reload=0.
        drive(0, 0, 1, 0); tick();
        n_run++;
        if (bus.y !== 4'd0 || bus.tc !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reload: y=%0d tc=%b busy=%b done=%b, expected y=0 tc=1 busy=0 done=1",
                     bus.y, bus.tc, bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        drive(1, 5, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        n_run++;
        if (bus.y !== 4'd5 || bus.tc !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start: y=%0d tc=%b busy=%b done=%b, expected y=5 tc=0 busy=1 done=0",
                     bus.y, bus.tc, bus.busy, bus.done);
        end
        for (int i = 0; i < 7; i++) begin
            int ey; bit et, eb, ed;
            drive(0, 0, 0, 1); tick();
            ey = (i < 5) ? 4 - i : 0;
            et = (i == 4); eb = (i < 4); ed = (i >= 4);
            n_run++;
            if (bus.y !== W'(ey) || bus.tc !== et || bus.busy !== eb || bus.done !== ed) begin
                n_fail++;
                $display("FAIL basic[%0d]: y=%0d tc=%b busy=%b done=%b, expected y=%0d tc=%b busy=%b done=%b",
                         i, bus.y, bus.tc, bus.busy, bus.done, ey, et, eb, ed);
            end
        end
    endtask

    task automatic test_pause();
        int ey [6] = '{3, 3, 3, 2, 1, 0};
        bit pe [6] = '{1, 0, 0, 1, 1, 1};
        drive(1, 4, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        for (int i = 0; i < 6; i++) begin
            bit et, eb;
            // A start while paused in RUN must be ignored.
            drive(0, 0, (i == 2), pe[i]); tick();
            et = (i == 5); eb = (i < 5);
            n_run++;
            if (bus.y !== W'(ey[i]) || bus.tc !== et || bus.busy !== eb || bus.done !== et) begin
                n_fail++;
                $display("FAIL pause[%0d]: y=%0d tc=%b busy=%b done=%b, expected y=%0d tc=%b busy=%b done=%b",
                         i, bus.y, bus.tc, bus.busy, bus.done, ey[i], et, eb, et);
            end
        end
    endtask

    task automatic test_zero_max();
        drive(1, 0, 0, 0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 1); tick();
            n_run++;
            if (bus.y !== 4'd0 || bus.tc !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_start[%0d]: y=%0d tc=%b busy=%b done=%b, expected y=0 tc=1 busy=0 done=1",
                         k, bus.y, bus.tc, bus.busy, bus.done);
            end
            drive(0, 0, 0, 1); tick();
            n_run++;
            if (bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_hold[%0d]: tc=%b busy=%b done=%b, expected tc=0 busy=0 done=1",
                         k, bus.tc, bus.busy, bus.done);
            end
        end
        drive(1, 15, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        n_run++;
        if (bus.y !== 4'd15 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL max_start: y=%0d busy=%b, expected y=15 busy=1", bus.y, bus.busy);
        end
        for (int i = 1; i <= 15; i++) begin
            bit et;
            drive(0, 0, 0, 1); tick();
            et = (i == 15);
            n_run++;
            if (bus.y !== W'(15 - i) || bus.tc !== et || bus.done !== et || bus.busy !== !et) begin
                n_fail++;
                $display("FAIL max[%0d]: y=%0d tc=%b busy=%b done=%b, expected y=%0d tc=%b busy=%b done=%b",
                         i, bus.y, bus.tc, bus.busy, bus.done, 15 - i, et, !et, et);
            end
        end
    endtask

    task automatic test_abort();
        drive(1, 9, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 1); tick(); tick(); tick();
        n_run++;
        if (bus.y !== 4'd6) begin
            n_fail++;
            $display("FAIL abort_pre: y=%0d, expected y=6", bus.y);
        end
        drive(1, 2, 0, 1); tick();
        n_run++;
        if (bus.y !== 4'd2 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_load: y=%0d tc=%b busy=%b done=%b, expected y=2 tc=0 busy=0 done=0",
                     bus.y, bus.tc, bus.busy, bus.done);
        end
        // en alone in IDLE must not move the count.
        drive(0, 0, 0, 1); tick();
        n_run++;
        if (bus.y !== 4'd2 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_en: y=%0d busy=%b, expected y=2 busy=0", bus.y, bus.busy);
        end
        for (int r = 0; r < 3; r++) begin
            drive(0, 0, 1, 0); tick();
            for (int i = 0; i < 2; i++) begin
                drive(0, 0, 0, 1); tick();
                n_run++;
                if (bus.y !== W'(1 - i) || bus.tc !== (i == 1) || bus.done !== (i == 1)) begin
                    n_fail++;
                    $display("FAIL restart[%0d.%0d]: y=%0d tc=%b done=%b, expected y=%0d tc=%b done=%b",
                             r, i, bus.y, bus.tc, bus.done, 1 - i, (i == 1), (i == 1));
                end
            end
        end
        // load coincident with what would be a terminal count: load wins.
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 1); tick();
        drive(1, 3, 0, 1); tick();
        n_run++;
        if (bus.y !== 4'd3 || bus.tc !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_vs_tc: y=%0d tc=%b busy=%b done=%b, expected y=3 tc=0 busy=0 done=0",
                     bus.y, bus.tc, bus.busy, bus.done);
        end
    endtask

    task automatic test_auto_reload();
        int ey [8] = '{1, 0, 2, 1, 0, 2, 1, 0};
        drive(1, 2, 0, 0); tick();
        drive(0, 0, 1, 1); tick();
        n_run++;
        if (bus.y !== 4'd2 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_start: y=%0d busy=%b, expected y=2 busy=1", bus.y, bus.busy);
        end
        for (int i = 0; i < 8; i++) begin
            bit et;
            drive(0, 0, 0, 1); tick();
            et = (ey[i] == 0);
            n_run++;
            if (bus.y !== W'(ey[i]) || bus.tc !== et || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL auto[%0d]: y=%0d tc=%b busy=%b done=%b, expected y=%0d tc=%b busy=1 done=0",
                         i, bus.y, bus.tc, bus.busy, bus.done, ey[i], et);
            end
        end
        drive(1, 5, 0, 1); tick();
        n_run++;
        if (bus.busy !== 1'b0 || bus.y !== 4'd5) begin
            n_fail++;
            $display("FAIL auto_exit: y=%0d busy=%b, expected y=5 busy=0", bus.y, bus.busy);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; drive(0, 0, 0, 0); tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0));
            tick();
            n_run++;
            if (bus.y !== W'(m_y) || bus.tc !== m_tc || bus.busy !== m_run || bus.done !== m_done) begin
                n_fail++;
                $display("FAIL random[%0d]: y=%0d tc=%b busy=%b done=%b, expected y=%0d tc=%b busy=%b done=%b",
                         i, bus.y, bus.tc, bus.busy, bus.done, m_y, m_tc, m_run, m_done);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        test_reset();
`ifdef DN_CNTR_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_basic();
        test_pause();
        test_zero_max();
        test_abort();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dn_cntr_4.md
Name: dn_cntr_4

Overview:
- Loadable down-counter / one-shot timer; the count-down counterpart of the team's 4-bit free-running up counter.
- Counts a programmed value down to zero, then flags terminal count.
- Used for delay and timeout generation in sequential test designs; driven by a controller through load/start/en.

Parameters:
WIDTH, 4, counter and load-value width in bits (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  capture load_val into reload register and y
load_val  input  WIDTH  value to count down from
start  input  1  begin countdown from reload register
en  input  1  count enable; 0 pauses in place
y  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse, one cycle, coincident with y first reading 0
busy  output  1  high while in RUN
done  output  1  high in DONE until next start or load

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst, sampled on clk rising edge); all outputs registered.
- Reset:
  - y=0, tc=0, busy=0, done=0, reload_reg=0, state=IDLE.
  - rst has priority over all other inputs, including mid-count.
- States: IDLE, RUN, DONE. Input priority: rst > load > start > en.
- load (any state):
  - Next cycle: reload_reg=load_val, y=load_val, state=IDLE, busy=0, done=0, tc=0.
  - Aborts a RUN in progress.
- start in IDLE or DONE:
  - Next cycle: y=reload_reg, done=0.
  - If reload_reg!=0: state=RUN, busy=1.
  - If reload_reg==0: state=DONE, done=1, tc=1 for one cycle (zero-length count).
- start in RUN: ignored.
- RUN, en=1, y>1: y=y-1 next cycle.
- RUN, en=1, y==1: next cycle y=0, tc=1, state=DONE, done=1, busy=0.
- RUN, en=0: y, state and outputs hold; tc=0.
- en has no effect in IDLE or DONE.
- Latency:
  - start sampled at edge n gives busy=1 and y=reload_reg after edge n.
  - Reaching 0 takes reload_reg enabled cycles after that.
- Underflow: y never wraps below 0 (without the optional feature); DONE holds y=0.
- tc is high for exactly one cycle per terminal event, including when load and terminal count would coincide (load wins, no tc).
- Arithmetic: unsigned WIDTH-bit; max count 2^WIDTH-1 (15 at default).

Optional Feature:
- Macro: DN_CNTR_AUTO_RELOAD_EN.
- Defined:
  - RUN, en=1, y==1: next cycle y=0, tc=1, state stays RUN, busy stays 1, done stays 0.
  - Next en=1 cycle: y=reload_reg, then counting continues.
  - Gives a periodic tc every reload_reg+1 enabled cycles.
  - Only load or rst exits RUN.
  - Zero-length start still goes to DONE.
- Undefined: terminal count enters DONE as above; no reload logic synthesized.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN with y=7 -> after release y=0, busy=0, done=0, tc=0, state IDLE.
- Basic count: load 5, start, en=1 continuous -> y=5,4,3,2,1,0 on consecutive cycles; tc=1 only when y=0; done=1 and busy=0 from that cycle on.
- Pause: load 4, start, en pattern 1,0,0,1,1,1 -> y=4,3,3,3,2,1,0; tc single pulse; done after 4 enabled cycles.
- Zero and max: load 0, start -> next cycle done=1, tc=1 pulse, busy never 1. Load 15, start -> 15 enabled cycles to y=0.
- Abort and restart: load 9, start, after 3 counts (y=6) assert load with load_val=2 -> y=2, IDLE, busy=0, no tc. Then start twice from DONE -> each run recounts 2,1,0.
- With DN_CNTR_AUTO_RELOAD_EN: load 2, start, en=1 for 9 cycles -> y=2,1,0,2,1,0,2,1,0; tc high on each 0; done stays 0; busy stays 1 until load.
